// File: rtl/compare_serial.sv
// compare_serial: multi-cycle MSB-first magnitude comparator, signed or unsigned, CHUNK bits per cycle
module compare_serial #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             signed_mode,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic             LT,
    output logic             GT,
    output logic             EQ
);
    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IW = NCHUNK > 1 ? $clog2(NCHUNK) : 1;
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
    typedef enum logic {IDLE, RUN} state_t;
    state_t state, state_n;
    logic [IW-1:0] idx, idx_n;
    logic [WIDTH-1:0] a_r, b_r, a_n, b_n;
    logic busy_n, done_n, lt_n, gt_n, eq_n;
    logic [CHUNK-1:0] ac [NCHUNK];
    logic [CHUNK-1:0] bc [NCHUNK];
    logic [CHUNK-1:0] a_c, b_c;
    for (genvar i = 0; i < NCHUNK; i++) begin : g_chunk
        assign ac[i] = a_r[i*CHUNK +: CHUNK];
        assign bc[i] = b_r[i*CHUNK +: CHUNK];
    end
    assign a_c = ac[idx];
    assign b_c = bc[idx];
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            a_r   <= '0;
            b_r   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            LT    <= 1'b0;
            GT    <= 1'b0;
            EQ    <= 1'b0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            a_r   <= a_n;
            b_r   <= b_n;
            busy  <= busy_n;
            done  <= done_n;
            LT    <= lt_n;
            GT    <= gt_n;
            EQ    <= eq_n;
        end
    end
    // Flipping the sign bit maps two's-complement order onto unsigned order.
    always_comb begin
        state_n = state;
        idx_n   = idx;
        a_n     = a_r;
        b_n     = b_r;
        busy_n  = busy;
        done_n  = 1'b0;
        lt_n    = LT;
        gt_n    = GT;
        eq_n    = EQ;
        case (state)
            IDLE: if (start) begin
                a_n     = A ^ (signed_mode ? MSB : '0);
                b_n     = B ^ (signed_mode ? MSB : '0);
                idx_n   = IW'(NCHUNK - 1);
                lt_n    = 1'b0;
                gt_n    = 1'b0;
                eq_n    = 1'b0;
                busy_n  = 1'b1;
                state_n = RUN;
            end
            RUN: if (a_c != b_c || idx == '0) begin
                lt_n    = a_c < b_c;
                gt_n    = a_c > b_c;
                eq_n    = a_c == b_c;
                done_n  = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end else begin
                idx_n = idx - 1'b1;
            end
            default: state_n = IDLE;
        endcase
    end
endmodule
